// File: rtl/disk_pkg.sv
// Shared constants for the RiSC disk controller: register map, request and
// status codes, and FSM state encodings.
package disk_pkg;

  localparam logic [15:0] DISK_BASE      = 16'h7f10;
  localparam int          DISK_MAX_WORDS = 1024;

  localparam logic [1:0] OFF_REQ = 2'd0;
  localparam logic [1:0] OFF_AR1 = 2'd1;
  localparam logic [1:0] OFF_AR2 = 2'd2;
  localparam logic [1:0] OFF_RDY = 2'd3;

  localparam logic [15:0] REQ_NULL  = 16'h0000;
  localparam logic [15:0] REQ_DONE  = 16'h0001;
  localparam logic [15:0] REQ_READ  = 16'h1234;
  localparam logic [15:0] REQ_WRITE = 16'h4321;
  localparam logic [15:0] REQ_ERROR = 16'hffff;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_FETCH  = 3'd2;
  localparam state_t S_WAITD  = 3'd3;
  localparam state_t S_WRMEM  = 3'd4;
  localparam state_t S_FIN    = 3'd5;

  function automatic logic file_ok(input logic [15:0] file);
    return (file >= 16'd1) && (file <= 16'd3);
  endfunction

endpackage

// File: rtl/disk_regs.sv
// Disk I/O register window: address decode, read mux, and write priority
// between the CPU and the controller FSM.
module disk_regs
  import disk_pkg::*;
#(
  parameter logic [15:0] BASE = DISK_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_addr,
  input  logic        io_we,
  input  logic [15:0] io_wdata,
  input  logic        req_en,
  input  logic        req_clr,
  input  logic        rdy_set,
  input  logic [15:0] rdy_status,
  output logic        io_hit,
  output logic [15:0] io_rdata,
  output logic        req_go,
  output logic [15:0] req,
  output logic [15:0] ar1,
  output logic [15:0] ar2,
  output logic [15:0] rdy
);

  logic [1:0]  off;
  logic        wr;
  logic [15:0] req_nxt;

  // BASE is 4-aligned, so the low two address bits select the register.
  assign io_hit = (io_addr[15:2] == BASE[15:2]);
  assign off    = io_addr[1:0];
  assign wr     = io_we && io_hit;

  always_comb begin
    req_nxt = req;
    if (req_clr)
      req_nxt = '0;
    else if (wr && off == OFF_REQ && req_en)
      req_nxt = io_wdata;
  end

  // Lets the FSM leave IDLE on the same edge that stores the request.
  assign req_go = req_en && (req_nxt != REQ_NULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      req <= '0;
      ar1 <= '0;
      ar2 <= '0;
      rdy <= REQ_NULL;
    end else begin
      req <= req_nxt;
      if (wr && off == OFF_AR1) ar1 <= io_wdata;
      if (wr && off == OFF_AR2) ar2 <= io_wdata;
      if (rdy_set)
        rdy <= rdy_status;
      else if (wr && off == OFF_RDY)
        rdy <= io_wdata;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_hit) begin
      case (off)
        OFF_REQ: io_rdata = req;
        OFF_AR1: io_rdata = ar1;
        OFF_AR2: io_rdata = ar2;
        default: io_rdata = rdy;
      endcase
    end
  end

endmodule

// File: rtl/disk_ctrl.sv
// RiSC disk controller: request sequencing FSM, word counters and the DMA
// write path that streams disk words into main memory.
//   state  | meaning
//   IDLE   | waiting for a nonzero REQ
//   DECODE | latch file/ptr, clear REQ, classify request
//   FETCH  | one-cycle dsk_rd pulse
//   WAITD  | waiting for dsk_valid
//   WRMEM  | DMA write pending until mem_gnt
//   FIN    | status into RDY
module disk_ctrl
  import disk_pkg::*;
#(
  parameter logic [15:0] BASE      = DISK_BASE,
  parameter int          MAX_WORDS = DISK_MAX_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_addr,
  input  logic        io_we,
  input  logic [15:0] io_wdata,
  output logic        io_hit,
  output logic [15:0] io_rdata,
  output logic        dsk_rd,
  output logic [15:0] dsk_file,
  output logic [15:0] dsk_idx,
  input  logic        dsk_valid,
  input  logic [15:0] dsk_data,
  input  logic        dsk_last,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy
);

  state_t      state;
  logic [15:0] file_r, ptr, idx, data_r, status_r;
  logic        last_r;
  logic        req_go;
  logic [15:0] req, ar1, ar2, rdy;

  disk_regs #(.BASE(BASE)) u_regs (
    .clk        (clk),
    .reset      (reset),
    .io_addr    (io_addr),
    .io_we      (io_we),
    .io_wdata   (io_wdata),
    .req_en     (state == S_IDLE),
    .req_clr    (state == S_DECODE),
    .rdy_set    (state == S_FIN),
    .rdy_status (status_r),
    .io_hit     (io_hit),
    .io_rdata   (io_rdata),
    .req_go     (req_go),
    .req        (req),
    .ar1        (ar1),
    .ar2        (ar2),
    .rdy        (rdy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      file_r   <= '0;
      ptr      <= '0;
      idx      <= '0;
      data_r   <= '0;
      last_r   <= 1'b0;
      status_r <= REQ_NULL;
    end else begin
      case (state)
        S_IDLE:
          if (req_go) state <= S_DECODE;
        S_DECODE: begin
          file_r <= ar1;
          ptr    <= ar2;
          idx    <= '0;
          if (req == REQ_READ && file_ok(ar1)) begin
            state <= S_FETCH;
          end else begin
            status_r <= (req == REQ_WRITE) ? REQ_DONE : REQ_ERROR;
            state    <= S_FIN;
          end
        end
        S_FETCH:
          state <= S_WAITD;
        S_WAITD:
          if (dsk_valid) begin
            data_r <= dsk_data;
            last_r <= dsk_last;
            state  <= S_WRMEM;
          end
        S_WRMEM:
          if (mem_gnt) begin
            ptr <= ptr + 16'd1;
            idx <= idx + 16'd1;
            // A final word that also hits the limit still completes cleanly.
            if (last_r) begin
              status_r <= REQ_DONE;
              state    <= S_FIN;
            end else if (idx == 16'(MAX_WORDS - 1)) begin
              status_r <= REQ_ERROR;
              state    <= S_FIN;
            end else begin
              state <= S_FETCH;
            end
          end
        S_FIN:
          state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  assign dsk_rd    = (state == S_FETCH);
  assign dsk_file  = file_r;
  assign dsk_idx   = idx;
  assign mem_req   = (state == S_WRMEM);
  assign mem_addr  = ptr;
  assign mem_wdata = data_r;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_disk_ctrl.sv
// Self-checking bench for disk_ctrl: randomized disk latency, grant timing and
// file contents, scored against a transfer-level model of the controller.
module tb_disk_ctrl;

  logic        clk, reset;
  logic [15:0] io_addr, io_wdata, io_rdata;
  logic        io_we, io_hit;
  logic        dsk_rd, dsk_valid, dsk_last;
  logic [15:0] dsk_file, dsk_idx, dsk_data;
  logic        mem_req, mem_gnt, busy;
  logic [15:0] mem_addr, mem_wdata;

  localparam logic [15:0] A_REQ = 16'h7f10;
  localparam logic [15:0] A_AR1 = 16'h7f11;
  localparam logic [15:0] A_AR2 = 16'h7f12;
  localparam logic [15:0] A_RDY = 16'h7f13;

  int checks = 0;
  int errors = 0;

  logic [15:0] disk_words[$];
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  logic [15:0] exp_file;
  int rd_count, gnt_mode, hold_at, hold_left, stall_cnt, disk_lat_max;
  logic spur;

  disk_ctrl dut (
    .clk(clk), .reset(reset),
    .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata),
    .io_hit(io_hit), .io_rdata(io_rdata),
    .dsk_rd(dsk_rd), .dsk_file(dsk_file), .dsk_idx(dsk_idx),
    .dsk_valid(dsk_valid), .dsk_data(dsk_data), .dsk_last(dsk_last),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Disk model: answers each dsk_rd after a random delay with the file word.
  initial begin
    dsk_valid = 1'b0;
    dsk_data  = 16'h0;
    dsk_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (dsk_rd === 1'b1 && reset === 1'b0) begin
        int i;
        i = int'(dsk_idx);
        checks++;
        if (dsk_idx !== 16'(rd_count)) begin
          errors++;
          $display("FAIL dsk_idx: got %h expected %h", dsk_idx, 16'(rd_count));
        end
        checks++;
        if (dsk_file !== exp_file) begin
          errors++;
          $display("FAIL dsk_file: got %h expected %h", dsk_file, exp_file);
        end
        rd_count++;
        repeat (1 + $urandom_range(0, disk_lat_max)) @(negedge clk);
        dsk_valid = 1'b1;
        dsk_data  = (i < disk_words.size()) ? disk_words[i] : 16'h0;
        dsk_last  = (i == disk_words.size() - 1);
        @(negedge clk);
        dsk_valid = 1'b0;
        dsk_data  = 16'($urandom);
        dsk_last  = 1'($urandom_range(0, 1));
      end else if (spur) begin
        dsk_valid = 1'b1;
        dsk_data  = 16'hdead;
        dsk_last  = 1'b1;
        @(negedge clk);
        dsk_valid = 1'b0;
        spur = 1'b0;
      end
    end
  end

  // Memory model: gnt_mode 0 random, 1 never, 2 always; optional stall window.
  initial begin
    logic        g, prev_wait;
    logic [15:0] prev_addr, prev_data;
    mem_gnt   = 1'b0;
    prev_wait = 1'b0;
    prev_addr = 16'h0;
    prev_data = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (prev_wait) begin
          checks++;
          if (mem_addr !== prev_addr || mem_wdata !== prev_data) begin
            errors++;
            $display("FAIL dma_stable: got %h/%h expected %h/%h",
                     mem_addr, mem_wdata, prev_addr, prev_data);
          end
        end
        g = (gnt_mode == 0) ? 1'($urandom_range(0, 1)) : (gnt_mode == 2);
        if (hold_left > 0 && log_addr.size() == hold_at) begin
          g = 1'b0;
          hold_left--;
        end
        mem_gnt = g;
        if (g) begin
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wdata);
        end else begin
          stall_cnt++;
        end
        prev_wait = !g;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
      end else begin
        mem_gnt   = (gnt_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        prev_wait = 1'b0;
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr  = a;
    io_wdata = d;
    io_we    = 1'b1;
    @(negedge clk);
    io_we    = 1'b0;
    io_addr  = 16'h0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    io_addr = a;
    #1;
    d = io_rdata;
  endtask

  task automatic fill_words(input int len);
    disk_words.delete();
    for (int i = 0; i < len; i++) disk_words.push_back(16'($urandom));
  endtask

  task automatic start_req(input logic [15:0] code, input logic [15:0] file,
                           input logic [15:0] ptr);
    log_addr.delete();
    log_data.delete();
    rd_count  = 0;
    stall_cnt = 0;
    exp_file  = file;
    cpu_write(A_AR1, file);
    cpu_write(A_AR2, ptr);
    cpu_write(A_RDY, 16'h0);
    cpu_write(A_REQ, code);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy %b after %0d cycles expected 0", busy, n);
    end
  endtask

  // Reference model: words written and final RDY value for one request.
  function automatic int model_nwords(input logic [15:0] code, input logic [15:0] file,
                                      input int len);
    if (code == 16'h1234 && file >= 16'd1 && file <= 16'd3)
      return (len < 1024) ? len : 1024;
    return 0;
  endfunction

  function automatic logic [15:0] model_status(input logic [15:0] code,
                                               input logic [15:0] file, input int len);
    if (code == 16'h1234 && file >= 16'd1 && file <= 16'd3)
      return (len <= 1024) ? 16'h0001 : 16'hffff;
    if (code == 16'h4321) return 16'h0001;
    return 16'hffff;
  endfunction

  task automatic test_reset();
    logic [15:0] v;
    logic [15:0] addrs[4];
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, dsk_rd, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 000", {busy, dsk_rd, mem_req});
    end
    checks++;
    if ({mem_addr, mem_wdata, dsk_file, dsk_idx} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, dsk_file, dsk_idx});
    end
    addrs = '{A_REQ, A_AR1, A_AR2, A_RDY};
    for (int i = 0; i < 4; i++) begin
      cpu_read(addrs[i], v);
      checks++;
      if (v !== 16'h0 || io_hit !== 1'b1) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h hit %b expected 0000 hit 1", i, v, io_hit);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_regs();
    logic [15:0] a1, a2, r, v;
    a1 = 16'($urandom);
    a2 = 16'($urandom);
    r  = 16'($urandom);
    cpu_write(A_AR1, a1);
    cpu_write(A_AR2, a2);
    cpu_write(A_RDY, r);
    cpu_read(A_AR1, v);
    checks++;
    if (v !== a1) begin errors++; $display("FAIL reg_ar1: got %h expected %h", v, a1); end
    cpu_read(A_AR2, v);
    checks++;
    if (v !== a2) begin errors++; $display("FAIL reg_ar2: got %h expected %h", v, a2); end
    cpu_read(A_RDY, v);
    checks++;
    if (v !== r) begin errors++; $display("FAIL reg_rdy: got %h expected %h", v, r); end
    cpu_read(16'h7f14, v);
    checks++;
    if (v !== 16'h0 || io_hit !== 1'b0) begin
      errors++;
      $display("FAIL nohit_7f14: got %h hit %b expected 0000 hit 0", v, io_hit);
    end
    cpu_read(16'h7f0f, v);
    checks++;
    if (v !== 16'h0 || io_hit !== 1'b0) begin
      errors++;
      $display("FAIL nohit_7f0f: got %h hit %b expected 0000 hit 0", v, io_hit);
    end
    cpu_read(A_REQ, v);
    checks++;
    if (v !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reg_req_idle: got %h busy %b expected 0000 busy 0", v, busy);
    end
  endtask

  task automatic test_read_basic();
    logic [15:0] v;
    disk_words = '{16'ha1a1, 16'hb2b2, 16'hc3c3};
    gnt_mode = 0;
    disk_lat_max = 2;
    start_req(16'h1234, 16'd1, 16'h0200);
    checks++;
    if (dsk_rd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_decode: got rd %b busy %b expected rd 0 busy 1", dsk_rd, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dsk_rd !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_rd: got %b expected 1", dsk_rd);
    end
    wait_idle(200);
    checks++;
    if (log_addr.size() != 3) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 3", log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 3; i++) begin
      checks++;
      if (log_addr[i] !== 16'(16'h0200 + i) || log_data[i] !== disk_words[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %h=%h expected %h=%h", i, log_addr[i], log_data[i],
                 16'(16'h0200 + i), disk_words[i]);
      end
    end
    cpu_read(A_RDY, v);
    checks++;
    if (v !== 16'h0001) begin errors++; $display("FAIL basic_rdy: got %h expected 0001", v); end
    cpu_read(A_REQ, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL basic_req: got %h expected 0000", v); end
  endtask

  task automatic test_gnt_hold();
    fill_words(3);
    gnt_mode  = 2;
    hold_at   = 1;
    hold_left = 5;
    start_req(16'h1234, 16'd2, 16'h0300);
    wait_idle(200);
    checks++;
    if (stall_cnt != 5 || rd_count != 3) begin
      errors++;
      $display("FAIL hold_stall: got stalls %0d reads %0d expected 5 and 3", stall_cnt, rd_count);
    end
    checks++;
    if (log_addr.size() != 3) begin
      errors++;
      $display("FAIL hold_count: got %0d expected 3", log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 3; i++) begin
      checks++;
      if (log_addr[i] !== 16'(16'h0300 + i) || log_data[i] !== disk_words[i]) begin
        errors++;
        $display("FAIL hold_word%0d: got %h=%h expected %h=%h", i, log_addr[i], log_data[i],
                 16'(16'h0300 + i), disk_words[i]);
      end
    end
    hold_at  = -1;
    gnt_mode = 0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a[4];
    logic [15:0] v;
    exp_a = '{16'hfffe, 16'hffff, 16'h0000, 16'h0001};
    fill_words(4);
    start_req(16'h1234, 16'd3, 16'hfffe);
    wait_idle(300);
    checks++;
    if (log_addr.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected 4", log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 4; i++) begin
      checks++;
      if (log_addr[i] !== exp_a[i] || log_data[i] !== disk_words[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: got %h=%h expected %h=%h", i, log_addr[i], log_data[i],
                 exp_a[i], disk_words[i]);
      end
    end
    cpu_read(A_RDY, v);
    checks++;
    if (v !== 16'h0001) begin errors++; $display("FAIL wrap_rdy: got %h expected 0001", v); end
  endtask

  task automatic test_write_req();
    logic [15:0] v;
    fill_words(2);
    start_req(16'h4321, 16'd1, 16'h0500);
    cpu_read(A_REQ, v);
    checks++;
    if (v !== 16'h4321 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_n: got req %h busy %b expected 4321 busy 1", v, busy);
    end
    @(negedge clk);
    cpu_read(A_RDY, v);
    checks++;
    if (v !== 16'h0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_n1: got rdy %h busy %b expected 0000 busy 1", v, busy);
    end
    cpu_read(A_REQ, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL write_req_clr: got %h expected 0000", v); end
    @(negedge clk);
    cpu_read(A_RDY, v);
    checks++;
    if (v !== 16'h0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_n2: got rdy %h busy %b expected 0001 busy 0", v, busy);
    end
    checks++;
    if (rd_count != 0 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL write_activity: got reads %0d writes %0d expected 0 0", rd_count, log_addr.size());
    end
  endtask

  task automatic test_bad_requests();
    logic [15:0] v;
    logic [15:0] codes[2];
    logic [15:0] files[2];
    codes = '{16'h5555, 16'h1234};
    files = '{16'd1, 16'd7};
    fill_words(3);
    for (int k = 0; k < 2; k++) begin
      start_req(codes[k], files[k], 16'h0600);
      wait_idle(50);
      cpu_read(A_RDY, v);
      checks++;
      if (v !== 16'hffff) begin errors++; $display("FAIL bad%0d_rdy: got %h expected ffff", k, v); end
      checks++;
      if (rd_count != 0 || log_addr.size() != 0) begin
        errors++;
        $display("FAIL bad%0d_activity: got reads %0d writes %0d expected 0 0", k, rd_count,
                 log_addr.size());
      end
    end
  endtask

  task automatic test_busy_drop();
    logic [15:0] v;
    fill_words(2);
    disk_lat_max = 6;
    start_req(16'h1234, 16'd3, 16'h0400);
    cpu_write(A_REQ, 16'h5555);
    cpu_write(A_AR1, 16'd2);
    wait_idle(200);
    cpu_read(A_RDY, v);
    checks++;
    if (v !== 16'h0001) begin errors++; $display("FAIL drop_rdy: got %h expected 0001", v); end
    cpu_read(A_REQ, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL drop_req: got %h expected 0000", v); end
    checks++;
    if (log_addr.size() != 2 || rd_count != 2) begin
      errors++;
      $display("FAIL drop_count: got writes %0d reads %0d expected 2 2", log_addr.size(), rd_count);
    end
    spur = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || log_addr.size() != 2 || spur !== 1'b0) begin
      errors++;
      $display("FAIL spurious_valid: got busy %b writes %0d expected busy 0 writes 2",
               busy, log_addr.size());
    end
    disk_lat_max = 2;
  endtask

  task automatic test_random();
    logic [15:0] code, file, ptr, v, st;
    int len, n, r;
    for (int it = 0; it < 8; it++) begin
      r    = $urandom_range(0, 9);
      code = (r < 7) ? 16'h1234 : (r == 7) ? 16'h4321 : 16'h0777;
      file = 16'($urandom_range(0, 4));
      ptr  = 16'($urandom);
      len  = $urandom_range(1, 12);
      disk_lat_max = $urandom_range(0, 3);
      fill_words(len);
      start_req(code, file, ptr);
      wait_idle(20 * len + 100);
      n  = model_nwords(code, file, len);
      st = model_status(code, file, len);
      checks++;
      if (log_addr.size() != n || rd_count != n) begin
        errors++;
        $display("FAIL rand%0d_count: got writes %0d reads %0d expected %0d", it,
                 log_addr.size(), rd_count, n);
      end
      for (int i = 0; i < log_addr.size() && i < n; i++) begin
        checks++;
        if (log_addr[i] !== 16'(ptr + i) || log_data[i] !== disk_words[i]) begin
          errors++;
          $display("FAIL rand%0d_word%0d: got %h=%h expected %h=%h", it, i, log_addr[i],
                   log_data[i], 16'(ptr + i), disk_words[i]);
        end
      end
      cpu_read(A_RDY, v);
      checks++;
      if (v !== st) begin errors++; $display("FAIL rand%0d_rdy: got %h expected %h", it, v, st); end
    end
    disk_lat_max = 2;
  endtask

  task automatic test_max_words();
    logic [15:0] v, st;
    int lens[2];
    int n, bad;
    lens = '{1100, 1024};
    gnt_mode = 2;
    disk_lat_max = 0;
    for (int k = 0; k < 2; k++) begin
      fill_words(lens[k]);
      start_req(16'h1234, 16'd1, 16'h8000);
      wait_idle(20 * lens[k] + 100);
      n  = model_nwords(16'h1234, 16'd1, lens[k]);
      st = model_status(16'h1234, 16'd1, lens[k]);
      checks++;
      if (log_addr.size() != n || rd_count != n) begin
        errors++;
        $display("FAIL max%0d_count: got writes %0d reads %0d expected %0d", k,
                 log_addr.size(), rd_count, n);
      end
      bad = 0;
      for (int i = 0; i < log_addr.size() && i < n; i++)
        if (log_addr[i] !== 16'(16'h8000 + i) || log_data[i] !== disk_words[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL max%0d_data: got %0d bad words expected 0", k, bad); end
      cpu_read(A_RDY, v);
      checks++;
      if (v !== st) begin errors++; $display("FAIL max%0d_rdy: got %h expected %h", k, v, st); end
    end
    gnt_mode = 0;
    disk_lat_max = 2;
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    int n;
    fill_words(5);
    gnt_mode = 1;
    start_req(16'h1234, 16'd2, 16'h0100);
    cpu_write(A_RDY, 16'h5a5a);
    n = 0;
    while (mem_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_reach: got mem_req %b expected 1", mem_req);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, mem_req, dsk_rd} !== 3'b000 || mem_addr !== 16'h0 || dsk_idx !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_out: got %b addr %h idx %h expected 000 0000 0000",
               {busy, mem_req, dsk_rd}, mem_addr, dsk_idx);
    end
    cpu_read(A_RDY, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL rst_mid_rdy: got %h expected 0000", v); end
    reset = 1'b0;
    gnt_mode = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (log_addr.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: got writes %0d busy %b expected 0 0", log_addr.size(), busy);
    end
  endtask

  initial begin
    reset        = 1'b1;
    io_addr      = 16'h0;
    io_we        = 1'b0;
    io_wdata     = 16'h0;
    gnt_mode     = 0;
    hold_at      = -1;
    hold_left    = 0;
    stall_cnt    = 0;
    disk_lat_max = 2;
    exp_file     = 16'h0;
    rd_count     = 0;
    spur         = 1'b0;
    test_reset();
    test_regs();
    test_read_basic();
    test_gnt_hold();
    test_wrap();
    test_write_req();
    test_bad_requests();
    test_busy_drop();
    test_random();
    test_max_words();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disk_ctrl.md
# disk_ctrl

Memory-mapped disk controller for the RiSC system. It decodes the four disk I/O registers at 0x7f10–0x7f13 and sequences each request. READ requests are serviced by streaming words from a word-serial disk source into main memory over a DMA write port, which is arbitrated against the CPU by an external grant. It replaces the behavioural disk process used in simulation with synthesizable RTL.

## Interface
- `BASE`, 16'h7f10, address of REQ; AR1 = BASE+1, AR2 = BASE+2, RDY = BASE+3
- `MAX_WORDS`, 1024, maximum words per READ before the transfer is aborted with an error
- `clk` in 1: system clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `io_addr` in 16: CPU data-bus address.
- `io_we` in 1: CPU store strobe, one cycle.
- `io_wdata` in 16: CPU store data.
- `io_hit` out 1: combinational, high when `io_addr` is in BASE..BASE+3.
- `io_rdata` out 16: combinational read of the addressed register; 0 when there is no hit.
- `dsk_rd` out 1: one-cycle pulse requesting one word from the disk.
- `dsk_file` out 16: file number, latched from AR1.
- `dsk_idx` out 16: word index within the file, starting at 0.
- `dsk_valid` in 1: one-cycle pulse; word present on `dsk_data`.
- `dsk_data` in 16: word returned by the disk.
- `dsk_last` in 1: qualifies `dsk_valid`; this is the final word of the file.
- `mem_req` out 1: DMA write request, held until granted.
- `mem_gnt` in 1: the write completes in the cycle where `mem_req && mem_gnt`.
- `mem_addr` out 16: DMA target address.
- `mem_wdata` out 16: DMA write data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Registers: REQ, AR1, AR2, RDY, each 16 bits. All reset to 0 except RDY, which resets to REQ_NULL (0).
- Codes: REQ_NULL = 0, REQ_DONE = 1, REQ_READ = 16'h1234, REQ_WRITE = 16'h4321, REQ_ERROR = 16'hffff.
- CPU writes to AR1, AR2 and RDY are always accepted. A CPU write to REQ is accepted only when the state is IDLE; otherwise it is dropped.
- States:
  - IDLE: a nonzero REQ moves the FSM to DECODE.
  - DECODE: latches `file` = AR1, `ptr` = AR2, `idx` = 0, and clears REQ to 0. Then:
    - READ with file in 1..3 goes to FETCH.
    - READ with any other file goes to FIN with status ERROR.
    - WRITE goes to FIN with status DONE; the request is accepted and ignored.
    - Any other code goes to FIN with status ERROR.
  - FETCH: pulses `dsk_rd` for one cycle, then goes to WAITD.
  - WAITD: on `dsk_valid`, captures `dsk_data` and `dsk_last` and goes to WRMEM.
  - WRMEM: drives `mem_req`, with `mem_addr` = `ptr` and `mem_wdata` = the captured word. On grant:
    - `ptr` and `idx` each increment by 1, mod 2^16, so addresses wrap 0xffff→0x0000.
    - If the captured `last` was set, go to FIN with status DONE.
    - Else if `idx`+1 == MAX_WORDS, go to FIN with status ERROR.
    - Else go to FETCH.
  - FIN: writes the status into RDY and returns to IDLE.
- AR1/AR2 writes during a transfer do not affect it, because the values are latched in DECODE.
- If a CPU write to RDY and the FIN update occur in the same cycle, the FIN update wins.
- The DMA may overwrite the register window itself. That is the software's problem; the controller's registers are not part of memory.
- `reset` at any time aborts the transfer: state IDLE, all outputs low/0 on the next edge, registers return to their reset values.

## Timing
- REQ store at edge N: REQ = code after N, DECODE during N+1, REQ reads 0 after N+1.
- READ: first `dsk_rd` pulse in cycle N+2.
- `dsk_valid` in cycle M: `mem_req` is high from M+1 until granted.
- Grant in cycle G, not the last word: next `dsk_rd` in G+1.
- Grant in cycle G, last word: FIN in G+1, RDY = 1 and `busy` = 0 after G+1.
- WRITE or error request: RDY updates and `busy` falls after N+2.
- A `dsk_valid` outside WAITD is ignored.
- `mem_req`, `mem_addr` and `mem_wdata` stay stable while the request waits for grant.

## Structure
- Shared package `disk_pkg`: the request/status codes, the register offsets, and the state enum.
- Natural sub-module: `disk_regs`, the register file with address decode, read mux and write-priority logic.
- The FSM, counters and DMA datapath live in `disk_ctrl`.

## Test plan
- AR1 = 1, AR2 = 0x0200, REQ = 0x1234; disk returns 3 words A1A1/B2B2/C3C3 with `last` on the third → mem[0x200..0x202] written in order, RDY = 1, REQ = 0, `busy` low.
- `mem_gnt` withheld for 5 cycles on word 2 → `mem_req`/`mem_addr`/`mem_wdata` held stable, no extra `dsk_rd` issued, final memory contents correct.
- AR2 = 0xfffe, 4-word file → writes land at fffe, ffff, 0000, 0001.
- REQ = 0x4321 → no `dsk_rd`, RDY = 1 two cycles later.
- REQ = 0x5555 → RDY = ffff. Separately, AR1 = 7 with READ → RDY = ffff and no disk activity.
- Second REQ store while busy → dropped. `reset` mid-transfer → IDLE, `mem_req` low, RDY = 0, no further memory writes.
